// File: rtl/picomips_pkg.sv
// picomips_pkg: shared types and constants for the picoMIPS switch/LED
// handshake controller.
//   hs_state_e          : controller states (IDLE, LOAD, WAIT, SHOW, TIMEOUT)
//   DATA_W_DEFAULT      : default index/result width
//   LED_TIMEOUT_PATTERN : value shown on the LEDs when the cpu never answers
package picomips_pkg;

  localparam int         DATA_W_DEFAULT      = 8;
  localparam logic [7:0] LED_TIMEOUT_PATTERN = 8'hFF;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    WAIT    = 3'd2,
    SHOW    = 3'd3,
    TIMEOUT = 3'd4
  } hs_state_e;

endpackage

// File: rtl/switch_debounce.sv
// switch_debounce: 2-flop synchroniser followed by a debounce counter.
// clean follows the synchronised level only after that level has differed
// from clean for DEBOUNCE_CYCLES consecutive cycles; any return to the clean
// value clears the counter. Usable for any slow mechanical switch.
// Ports:
//   clk   in  : clock, all logic on posedge
//   reset in  : asynchronous active-high reset (sync flops, counter, clean -> 0)
//   raw   in  : asynchronous switch input
//   clean out : debounced level
module switch_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic clean
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q, sync_d;
  logic             clean_q, clean_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sync_d  = {sync_q[0], raw};
    clean_d = clean_q;
    cnt_d   = '0;
    if (sync_q[1] != clean_q) begin
      // The counter stops at CNT_LAST and the level is accepted on that
      // cycle, so it can never wrap back to zero mid-run.
      if (cnt_q >= CNT_LAST) begin
        clean_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= '0;
      clean_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= sync_d;
      clean_q <= clean_d;
      cnt_q   <= cnt_d;
    end
  end

  assign clean = clean_q;

endmodule

// File: rtl/picomips_handshake_ctrl.sv
// picomips_handshake_ctrl: sequences one picoMIPS transaction from the board
// switches to the LEDs. A debounced press of sw_handshake captures sw_index,
// pulses cpu_start, waits for cpu_done, shows cpu_result on led and re-arms
// once the switch is released.
// Optional feature macro: HS_TIMEOUT_EN -- adds a 16-bit WAIT cycle counter;
// after TIMEOUT_CYCLES without cpu_done the FSM enters TIMEOUT, sets the
// sticky timeout flag and shows LED_TIMEOUT_PATTERN. Without the macro WAIT
// waits forever and timeout is tied to 0.
// Ports:
//   clk, reset    : clock and asynchronous active-high reset
//   sw_handshake  : raw handshake switch
//   sw_index      : raw index switches (static while the switch is pressed)
//   cpu_start     : one-cycle start pulse, cpu_index valid with it
//   cpu_index     : captured index, held until the next LOAD
//   cpu_done      : cpu result valid (level or pulse), only sampled in WAIT
//   cpu_result    : cpu result, captured when cpu_done=1 in WAIT
//   led           : displayed result
//   busy          : 1 in every state except IDLE
//   timeout       : sticky timeout flag
//   dbg_state     : current FSM state
// Handshake: cpu_start is a single-cycle request that the cpu must accept
// without back-pressure; cpu_done is the response, ignored outside WAIT and
// accepted on the first WAIT cycle it is high (including the entry cycle).
module picomips_handshake_ctrl
  import picomips_pkg::*;
#(
  parameter int DATA_W          = DATA_W_DEFAULT,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sw_handshake,
  input  logic [DATA_W-1:0] sw_index,
  output logic              cpu_start,
  output logic [DATA_W-1:0] cpu_index,
  input  logic              cpu_done,
  input  logic [DATA_W-1:0] cpu_result,
  output logic [DATA_W-1:0] led,
  output logic              busy,
  output logic              timeout,
  output hs_state_e         dbg_state
);

  if (DEBOUNCE_CYCLES < 2 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_params
    $error("picomips_handshake_ctrl: DEBOUNCE_CYCLES must be >=2 and TIMEOUT_CYCLES in 2..65535");
  end

  // After reset the debouncer reports 0 even if the switch is held; a held
  // switch is only accepted DEBOUNCE_CYCLES+2 cycles later. Rising edges are
  // ignored until that window has passed, so a switch held through reset
  // must be released and pressed again.
  localparam int SETTLE_CYCLES = DEBOUNCE_CYCLES + 4;
  localparam int SET_W         = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES);

  logic hs_clean;

  switch_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_hs_debounce (
    .clk   (clk),
    .reset (reset),
    .raw   (sw_handshake),
    .clean (hs_clean)
  );

  hs_state_e         state_q, state_d;
  logic              cpu_start_q, cpu_start_d;
  logic [DATA_W-1:0] cpu_index_q, cpu_index_d;
  logic [DATA_W-1:0] led_q, led_d;
  logic              busy_q, busy_d;
  logic              hs_prev_q, hs_prev_d;
  logic [SET_W-1:0]  settle_q, settle_d;
  logic              settled, hs_rise;
`ifdef HS_TIMEOUT_EN
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0]       wait_cnt_q, wait_cnt_d;
  logic              timeout_q, timeout_d;
`endif

  assign settled = (settle_q == SETTLE_LAST);
  assign hs_rise = settled & hs_clean & ~hs_prev_q;

  always_comb begin
    state_d     = state_q;
    cpu_start_d = 1'b0;
    cpu_index_d = cpu_index_q;
    led_d       = led_q;
    hs_prev_d   = hs_clean;
    settle_d    = settled ? settle_q : settle_q + 1'b1;
`ifdef HS_TIMEOUT_EN
    wait_cnt_d  = wait_cnt_q;
    timeout_d   = timeout_q;
`endif
    case (state_q)
      IDLE: begin
        if (hs_rise) begin
          state_d     = LOAD;
          cpu_start_d = 1'b1;
          cpu_index_d = sw_index;
`ifdef HS_TIMEOUT_EN
          // Counts the LOAD cycle, so TIMEOUT is entered TIMEOUT_CYCLES
          // cycles after cpu_start.
          wait_cnt_d  = 16'd1;
`endif
        end
      end
      LOAD: state_d = WAIT;
      WAIT: begin
        if (cpu_done) begin
          led_d   = cpu_result;
          state_d = SHOW;
        end
`ifdef HS_TIMEOUT_EN
        else if (wait_cnt_q >= WAIT_LAST) begin
          led_d     = DATA_W'(LED_TIMEOUT_PATTERN);
          timeout_d = 1'b1;
          state_d   = TIMEOUT;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
`endif
      end
      SHOW: begin
        if (!hs_clean) state_d = IDLE;
      end
`ifdef HS_TIMEOUT_EN
      TIMEOUT: begin
        if (!hs_clean) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cpu_start_q <= 1'b0;
      cpu_index_q <= '0;
      led_q       <= '0;
      busy_q      <= 1'b0;
      hs_prev_q   <= 1'b0;
      settle_q    <= '0;
`ifdef HS_TIMEOUT_EN
      wait_cnt_q  <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cpu_start_q <= cpu_start_d;
      cpu_index_q <= cpu_index_d;
      led_q       <= led_d;
      busy_q      <= busy_d;
      hs_prev_q   <= hs_prev_d;
      settle_q    <= settle_d;
`ifdef HS_TIMEOUT_EN
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

  assign cpu_start = cpu_start_q;
  assign cpu_index = cpu_index_q;
  assign led       = led_q;
  assign busy      = busy_q;
  assign dbg_state = state_q;
`ifdef HS_TIMEOUT_EN
  assign timeout   = timeout_q;
`else
  assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_picomips_handshake_ctrl.sv
// Bench for picomips_handshake_ctrl: directed transactions, a scoreboard of
// expected cpu_index values (popped on every cpu_start) and expected led
// values (popped on every entry into SHOW), plus directed state checks.
module tb_picomips_handshake_ctrl;
  import picomips_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         sw_handshake;
  logic [W-1:0] sw_index;
  logic         cpu_start;
  logic [W-1:0] cpu_index;
  logic         cpu_done;
  logic [W-1:0] cpu_result;
  logic [W-1:0] led;
  logic         busy;
  logic         timeout;
  hs_state_e    dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int start_count = 0;
  int exp_starts  = 0;

  logic [W-1:0] exp_idx_q[$];
  logic [W-1:0] exp_led_q[$];

  picomips_handshake_ctrl #(
    .DATA_W          (W),
    .DEBOUNCE_CYCLES (16),
    .TIMEOUT_CYCLES  (20)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sw_handshake (sw_handshake),
    .sw_index     (sw_index),
    .cpu_start    (cpu_start),
    .cpu_index    (cpu_index),
    .cpu_done     (cpu_done),
    .cpu_result   (cpu_result),
    .led          (led),
    .busy         (busy),
    .timeout      (timeout),
    .dbg_state    (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input hs_state_e st, input int budget, input string name);
    for (int i = 0; i < budget && dbg_state != st; i++) tick(1);
    check(name, dbg_state, st);
  endtask

  task automatic wait_start(input int budget, input string name);
    for (int i = 0; i < budget && cpu_start !== 1'b1; i++) tick(1);
    check(name, cpu_start, 1);
  endtask

  task automatic press(input logic [W-1:0] idx);
    sw_index     = idx;
    sw_handshake = 1'b1;
  endtask

  task automatic expect_txn(input logic [W-1:0] idx);
    exp_idx_q.push_back(idx);
    exp_starts++;
  endtask

  // monitor / scoreboard
  hs_state_e prev_state = IDLE;
  logic      prev_start = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      prev_state = IDLE;
      prev_start = 1'b0;
    end else begin
      if (cpu_start) begin
        start_count++;
        if (prev_start) check("start_pulse_width", 2, 1);
        if (exp_idx_q.size() == 0) check("unexpected_start", 1, 0);
        else check("start_index", cpu_index, exp_idx_q.pop_front());
      end
      if (dbg_state == SHOW && prev_state != SHOW) begin
        if (exp_led_q.size() == 0) check("unexpected_show", 1, 0);
        else check("show_led", led, exp_led_q.pop_front());
      end
      prev_state = dbg_state;
      prev_start = cpu_start;
    end
  end

  // stimulus
  initial begin
    // 1: reset with random inputs
    reset        = 1'b1;
    sw_handshake = 1'($urandom_range(0, 1));
    sw_index     = W'($urandom_range(0, 255));
    cpu_done     = 1'($urandom_range(0, 1));
    cpu_result   = W'($urandom_range(0, 255));
    tick(3);
    check("reset_led", led, 0);
    check("reset_busy", busy, 0);
    check("reset_start", cpu_start, 0);
    check("reset_timeout", timeout, 0);
    check("reset_state", dbg_state, IDLE);
    sw_handshake = 1'b0;
    cpu_done     = 1'b0;
    reset        = 1'b0;
    tick(25);

    // 2: basic transaction
    expect_txn(8'h2A);
    exp_led_q.push_back(8'h7C);
    press(8'h2A);
    wait_start(60, "t2_start_seen");
    tick(4);
    cpu_result = 8'h7C;
    cpu_done   = 1'b1;
    tick(1);
    cpu_done   = 1'b0;
    tick(2);
    check("t2_led", led, 8'h7C);
    check("t2_busy_held", busy, 1);
    check("t2_state_show", dbg_state, SHOW);
    sw_handshake = 1'b0;
    wait_state(IDLE, 40, "t2_back_idle");
    check("t2_busy_released", busy, 0);
    check("t2_led_kept", led, 8'h7C);
    check("t2_start_count", start_count, exp_starts);

    // 3: bouncing switch never accepted
    for (int i = 0; i < 40; i++) begin
      if (i % 3 == 0) sw_handshake = ~sw_handshake;
      tick(1);
    end
    sw_handshake = 1'b0;
    tick(20);
    check("t3_state", dbg_state, IDLE);
    check("t3_busy", busy, 0);
    check("t3_start_count", start_count, exp_starts);

    // 4: release during WAIT, result still shown; cpu_done in IDLE ignored
    expect_txn(8'h5A);
    exp_led_q.push_back(8'h11);
    press(8'h5A);
    wait_start(60, "t4_start_seen");
    tick(1);
    sw_handshake = 1'b0;
    tick(25);
    check("t4_wait_state", dbg_state, WAIT);
    check("t4_wait_busy", busy, 1);
    cpu_result = 8'h11;
    cpu_done   = 1'b1;
    tick(1);
    cpu_done   = 1'b0;
    tick(1);
    check("t4_led", led, 8'h11);
    tick(1);
    check("t4_idle_after_show", dbg_state, IDLE);
    cpu_result = 8'h33;
    cpu_done   = 1'b1;
    tick(1);
    cpu_done   = 1'b0;
    tick(3);
    check("t4_done_in_idle_led", led, 8'h11);
    check("t4_done_in_idle_state", dbg_state, IDLE);

    // 5: async reset in WAIT, held switch must be re-pressed
    tick(20);
    expect_txn(8'hC3);
    press(8'hC3);
    wait_start(60, "t5_start_seen");
    tick(2);
    check("t5_busy_in_wait", busy, 1);
    #2 reset = 1'b1;
    #1;
    check("t5_async_led", led, 0);
    check("t5_async_busy", busy, 0);
    check("t5_async_state", dbg_state, IDLE);
    tick(2);
    reset = 1'b0;
    tick(60);
    check("t5_held_no_start", start_count, exp_starts);
    check("t5_held_state", dbg_state, IDLE);
    sw_handshake = 1'b0;
    tick(25);
    // cpu_done already high when WAIT is entered
    expect_txn(8'h96);
    exp_led_q.push_back(8'h44);
    press(8'h96);
    wait_start(60, "t5_restart_seen");
    cpu_result = 8'h44;
    cpu_done   = 1'b1;
    tick(3);
    cpu_done   = 1'b0;
    check("t5_led_done_on_entry", led, 8'h44);
    sw_handshake = 1'b0;
    wait_state(IDLE, 40, "t5_back_idle");

`ifdef HS_TIMEOUT_EN
    // 6: cpu never answers
    tick(20);
    expect_txn(8'h01);
    press(8'h01);
    wait_start(60, "t6_start_seen");
    tick(19);
    check("t6_no_timeout_yet", timeout, 0);
    tick(1);
    check("t6_timeout", timeout, 1);
    check("t6_led_pattern", led, 8'hFF);
    check("t6_state", dbg_state, TIMEOUT);
    sw_handshake = 1'b0;
    wait_state(IDLE, 40, "t6_back_idle");
    check("t6_timeout_sticky", timeout, 1);
`else
    // without the timeout feature WAIT never gives up and timeout stays 0
    tick(20);
    expect_txn(8'h01);
    press(8'h01);
    wait_start(60, "t6_start_seen");
    tick(100);
    check("t6_still_wait", dbg_state, WAIT);
    check("t6_timeout_zero", timeout, 0);
    check("t6_led_kept", led, 8'h44);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    sw_handshake = 1'b0;
    tick(5);
`endif

    tick(5);
    check("end_idx_queue_empty", exp_idx_q.size(), 0);
    check("end_led_queue_empty", exp_led_q.size(), 0);
    check("end_start_count", start_count, exp_starts);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
